// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the I-memory.
// Fetch drives one request per cycle and holds the address until the memory answers with ready.
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
   modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, I-memory handshake and the IF/ID pipeline register.
// Redirects override hazard stalls; wrong-path responses are squashed while a request is outstanding.
module if_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        IF_ID_Write,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   input  logic        Jump,
   input  logic [31:0] Jump_Target,
   if_stage_if.master  mem,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_Instr,
   output logic        IF_ID_Valid,
   output logic        Fetch_Stall
);

   typedef enum logic [1:0] {FETCH, SQUASH, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] buffer;
   logic [31:0] saved_target;
   logic        redirect;
   logic        stall;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect = Branch_Taken | Jump;
   assign target   = (Branch_Taken ? Branch_Target : Jump_Target) & 32'hFFFF_FFFC;
   assign stall    = ~PCWrite | ~IF_ID_Write;
   assign pc_plus4 = pc + 32'd4;

   // The request is gated by reset so a mid-operation reset never issues a fetch.
   assign mem.imem_req  = ~rst & (state != HOLD);
   assign mem.imem_addr = pc;
   assign Fetch_Stall   = ~mem.imem_ready & (state != HOLD);

   // NOTE: every register here is written with <= so all of them see the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FETCH;
         pc           <= 32'h0;
         buffer       <= 32'h0;
         saved_target <= 32'h0;
         IF_ID_PC     <= 32'h0;
         IF_ID_Instr  <= 32'h0;
         IF_ID_Valid  <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  IF_ID_PC    <= 32'h0;
                  IF_ID_Instr <= 32'h0;
                  IF_ID_Valid <= 1'b0;
                  if (mem.imem_ready) begin
                     pc <= target;
                  end else begin
                     saved_target <= target;
                     state        <= SQUASH;
                  end
               end else if (mem.imem_ready) begin
                  if (stall) begin
                     buffer <= mem.imem_rdata;
                     state  <= HOLD;
                  end else begin
                     IF_ID_PC    <= pc_plus4;
                     IF_ID_Instr <= mem.imem_rdata;
                     IF_ID_Valid <= 1'b1;
                     pc          <= pc_plus4;
                  end
               end else if (IF_ID_Write) begin
                  IF_ID_PC    <= 32'h0;
                  IF_ID_Instr <= 32'h0;
                  IF_ID_Valid <= 1'b0;
               end
            end

            SQUASH: begin
               IF_ID_PC    <= 32'h0;
               IF_ID_Instr <= 32'h0;
               IF_ID_Valid <= 1'b0;
               if (mem.imem_ready) begin
                  pc    <= redirect ? target : saved_target;
                  state <= FETCH;
               end else if (redirect) begin
                  saved_target <= target;
               end
            end

            HOLD: begin
               if (redirect) begin
                  IF_ID_PC    <= 32'h0;
                  IF_ID_Instr <= 32'h0;
                  IF_ID_Valid <= 1'b0;
                  pc          <= target;
                  state       <= FETCH;
               end else if (!stall) begin
                  IF_ID_PC    <= pc_plus4;
                  IF_ID_Instr <= buffer;
                  IF_ID_Valid <= 1'b1;
                  pc          <= pc_plus4;
                  state       <= FETCH;
               end
            end

            default: state <= FETCH;
         endcase
      end
   end

endmodule
